// File: rtl/bus_write_bank.sv
// Bank of architectural registers loaded from the shared bus, each with its own
// prioritised clear / bus load / alternate load / increment / hold behaviour.
module bus_write_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [9:0]        write_en,
    input  logic [4:0]        inc_en,
    input  logic [3:0]        clr_en,
    input  logic [DATA_W-1:0] alu_in,
    input  logic              ac_alu_ld,
    input  logic [ADDR_W-1:0] dm_in,
    input  logic              dr_mem_ld,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] dr,
    output logic [DATA_W-1:0] tr,
    output logic [DATA_W-1:0] ac,
    output logic [ADDR_W-1:0] r,
    output logic [ADDR_W-1:0] r1,
    output logic [ADDR_W-1:0] r2,
    output logic [ADDR_W-1:0] ri,
    output logic [ADDR_W-1:0] rj,
    output logic [ADDR_W-1:0] rk,
    output logic              z
);

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);

    logic [ADDR_W-1:0] bus_lo;
    logic [ADDR_W-1:0] pc_q, dr_q, r_q, r1_q, r2_q, ri_q, rj_q, rk_q;
    logic [ADDR_W-1:0] pc_d, dr_d, r_d, r1_d, r2_d, ri_d, rj_d, rk_d;
    logic [DATA_W-1:0] tr_q, ac_q, tr_d, ac_d;
    logic              z_q, z_d;

    // Address-width registers keep only the low bits of the bus
    assign bus_lo = bus_in[ADDR_W-1:0];

    always_comb begin
        pc_d = pc_q;
        if (write_en[0])     pc_d = bus_lo;
        else if (inc_en[0])  pc_d = pc_q + ONE_A;

        dr_d = dr_q;
        if (write_en[1])     dr_d = bus_lo;
        else if (dr_mem_ld)  dr_d = dm_in;

        tr_d = write_en[2] ? bus_in : tr_q;

        ac_d = ac_q;
        if (clr_en[0])       ac_d = '0;
        else if (write_en[3]) ac_d = bus_in;
        else if (ac_alu_ld)  ac_d = alu_in;
        else if (inc_en[1])  ac_d = ac_q + ONE_D;

        r_d  = write_en[4] ? bus_lo : r_q;
        r1_d = write_en[5] ? bus_lo : r1_q;
        r2_d = write_en[6] ? bus_lo : r2_q;

        ri_d = ri_q;
        if (clr_en[1])       ri_d = '0;
        else if (write_en[7]) ri_d = bus_lo;
        else if (inc_en[2])  ri_d = ri_q + ONE_A;

        rj_d = rj_q;
        if (clr_en[2])       rj_d = '0;
        else if (write_en[8]) rj_d = bus_lo;
        else if (inc_en[3])  rj_d = rj_q + ONE_A;

        rk_d = rk_q;
        if (clr_en[3])       rk_d = '0;
        else if (write_en[9]) rk_d = bus_lo;
        else if (inc_en[4])  rk_d = rk_q + ONE_A;

        // Flag tracks the value AC will hold after this edge
        z_d = (ac_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            dr_q <= '0;
            tr_q <= '0;
            ac_q <= '0;
            r_q  <= '0;
            r1_q <= '0;
            r2_q <= '0;
            ri_q <= '0;
            rj_q <= '0;
            rk_q <= '0;
            z_q  <= 1'b1;
        end else begin
            pc_q <= pc_d;
            dr_q <= dr_d;
            tr_q <= tr_d;
            ac_q <= ac_d;
            r_q  <= r_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            ri_q <= ri_d;
            rj_q <= rj_d;
            rk_q <= rk_d;
            z_q  <= z_d;
        end
    end

    assign pc = pc_q;
    assign dr = dr_q;
    assign tr = tr_q;
    assign ac = ac_q;
    assign r  = r_q;
    assign r1 = r1_q;
    assign r2 = r2_q;
    assign ri = ri_q;
    assign rj = rj_q;
    assign rk = rk_q;
    assign z  = z_q;

endmodule

// File: doc/bus_write_bank.md
# bus_write_bank

Write-side counterpart of the shared datapath bus multiplexer. It decodes the control unit's write-enable bitmask and loads the 16-bit bus value into the processor's architectural registers (PC, DR, TR, AC, R, R1, R2, RI, RJ, RK). It also handles the per-register increment and clear operations, the ALU-to-AC path and the data-memory-to-DR path. Its register outputs drive the bus multiplexer's source inputs, closing the read/write loop of the single-core matrix-multiply datapath.

## Interface
Parameters:
- DATA_W, 16, width of bus, AC and TR
- ADDR_W, 8, width of PC, DR, R, R1, R2, RI, RJ, RK

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- bus_in  input  DATA_W  current bus value
- write_en  input  10  load-from-bus bitmask: bit0 PC, 1 DR, 2 TR, 3 AC, 4 R, 5 R1, 6 R2, 7 RI, 8 RJ, 9 RK
- inc_en  input  5  increment bitmask: bit0 PC, 1 AC, 2 RI, 3 RJ, 4 RK
- clr_en  input  4  clear bitmask: bit0 AC, 1 RI, 2 RJ, 3 RK
- alu_in  input  DATA_W  ALU result
- ac_alu_ld  input  1  load AC from alu_in
- dm_in  input  ADDR_W  data-memory read data
- dr_mem_ld  input  1  load DR from dm_in
- pc, dr, r, r1, r2, ri, rj, rk  output  ADDR_W each  register contents
- tr, ac  output  DATA_W each  register contents
- z  output  1  registered flag, 1 when AC value after the update is zero

## Operation
- All registers update only on the rising edge of clk. Each register is independent, and several may update in the same cycle.
- 8-bit registers load bus_in[7:0] and discard bus_in[15:8]. TR and AC load all 16 bits.
- Per-register priority, highest first: clear, bus write, alternate load (AC: ac_alu_ld; DR: dr_mem_ld), increment, hold.
- Increment is +1 modulo 2^width and wraps silently: 8'hFF -> 8'h00, 16'hFFFF -> 16'h0000. No carry output.
- z is computed from the next value of AC and registered with it, so it always matches the current ac output.
- Registers with no control bit for an operation ignore that operation. For example, PC has no clear, and TR has only bus write.
- There is no FSM. The behaviour is a bank of prioritised load/increment/clear counters. The implementation uses one always block per register, or an equivalent.

## Timing
- Reset: asserting rst forces every register output to 0 and z to 1 immediately, without waiting for a clock edge. This applies mid-operation, and any pending load in that cycle is lost.
- Reset release: the first rising edge after rst deasserts performs a normal update.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Read-modify-write in one cycle is legal. The bus multiplexer may drive a register's own value while that register's write_en bit is set; the old value is read and the new value is stored at the edge.
- Simultaneous events are resolved only by the priority list above. For example, write_en[3], inc_en[1] and ac_alu_ld all high loads bus_in into AC.
- Inputs must be stable around the rising edge. No combinational path exists from inputs to outputs.

## Test plan
- Reset: drive rst=1 mid-cycle after loading PC=8'h13. All outputs must read 0 and z=1 before the next edge, and must stay so while rst=1.
- Bus loads: cycle through write_en one-hot bits 0..9 with bus_in=16'hAB0A+bit. Only the selected register changes. 8-bit registers hold 8'h0A+bit; TR and AC hold 16'hAB0A+bit.
- Wrap-around: load RI=8'hFF then inc_en[2] -> RI=8'h00. Load AC=16'hFFFF then inc_en[1] -> AC=16'h0000 and z=1.
- Priority: with AC=16'h0005, assert clr_en[0], write_en[3], ac_alu_ld and inc_en[1] -> AC=0. Drop clr_en -> AC=bus_in. Drop write_en[3] -> AC=alu_in. Drop ac_alu_ld -> AC=alu_in+1.
- Multi-register update: write_en=10'b1110000000 with bus_in=16'h0011, plus inc_en[0] -> RI=RJ=RK=8'h11 and PC increments, all at the same edge.
- DR paths: dr_mem_ld with dm_in=8'h09 -> DR=8'h09. Then dr_mem_ld and write_en[1] with bus_in=16'h0022 -> DR=8'h22.
